// File: rtl/mux_arbiter.sv
// Round-robin arbiter that muxes one requester's data onto a shared registered path.
// Optional per-owner burst limit is enabled by defining MUX_ARB_BURST_LIMIT_EN.
module mux_arbiter #(
    parameter int S = 2,
    parameter int M = 3,
    parameter int L = 4,
    localparam int N = 2**S
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [M*N-1:0] din,
    output logic [N-1:0]   gnt,
    output logic [S-1:0]   sel,
    output logic [M-1:0]   dout,
    output logic           dvalid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_n;
    logic [S-1:0]   ptr;
    logic [S-1:0]   win;
    logic [S-1:0]   idx;
    logic [S-1:0]   owner_n;
    logic [N-1:0]   cand;
    logic [N-1:0]   gnt_n;
    logic           found;
    logic           change;
    logic           burst_hit;

    if (L < 1) begin : g_bad_l
        $error("mux_arbiter: L must be >= 1");
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    logic [CW-1:0] cnt;

    assign burst_hit = (cnt == CW'(L - 1));

    always_ff @(posedge clk) begin
        if (rst || change || state_n != GRANT)
            cnt <= '0;
        else if (burst_hit)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
`else
    assign burst_hit = 1'b0;
`endif

    // The current owner never competes in its own search, so a burst handover
    // and a release both pick the next requester after the pointer.
    always_comb begin
        cand  = (state == GRANT) ? (req & ~gnt) : req;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + S'(k);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        owner_n = sel;
        change  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    owner_n = win;
                    change  = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    if (found) begin
                        owner_n = win;
                        change  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        owner_n = '0;
                    end
                end else if (burst_hit && found) begin
                    owner_n = win;
                    change  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = '0;
            end
        endcase
        gnt_n          = '0;
        gnt_n[owner_n] = (state_n == GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            sel    <= '0;
            ptr    <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            sel    <= (state_n == GRANT) ? owner_n : '0;
            if (change)
                ptr <= owner_n + 1'b1;
            dvalid <= (state == GRANT);
            dout   <= (state == GRANT) ? din[sel*M +: M] : '0;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus random traffic against an integer-level model.
module tb_mux_arbiter;

    localparam int S = 2;
    localparam int M = 3;
    localparam int L = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [M*N-1:0] din;
    logic [N-1:0]   gnt;
    logic [S-1:0]   sel;
    logic [M-1:0]   dout;
    logic           dvalid;

    int nvec = 0;
    int nmis = 0;

    // model state: owner = -1 when idle
    int m_owner, m_ptr, m_cnt;
    int e_gnt, e_sel, e_dout, e_dv;

    mux_arbiter #(.S(S), .M(M), .L(L)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt), .sel(sel), .dout(dout), .dvalid(dvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_winner(input int from, input int exclude);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (from + k) % N;
            if (req[i] && i != exclude) return i;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
            e_dout = 0; e_dv = 0;
        end else begin
            if (m_owner >= 0) begin
                e_dout = (din >> (M * m_owner)) & ((1 << M) - 1);
                e_dv   = 1;
            end else begin
                e_dout = 0;
                e_dv   = 0;
            end
            w = find_winner(m_ptr, m_owner);
            if (m_owner < 0) begin
                if (w >= 0) take(w);
            end else if (!req[m_owner]) begin
                if (w >= 0) take(w);
                else begin m_owner = -1; m_cnt = 0; end
            end else begin
`ifdef MUX_ARB_BURST_LIMIT_EN
                if (m_cnt == L - 1 && w >= 0) take(w);
                else m_cnt = (m_cnt + 1) % L;
`endif
            end
        end
        e_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        e_sel = (m_owner < 0) ? 0 : m_owner;
    endtask

    // One clock: model sees the inputs present at the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("sel", 32'(sel), 32'(e_sel));
        check("dout", 32'(dout), 32'(e_dout));
        check("dvalid", 32'(dvalid), 32'(e_dv));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_req [5];
        int rr_exp [5];
        rr_req = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rr_exp = '{0, 1, 2, 3, 0};

        // reset held two cycles with all requests high
        rst = 1'b1; req = 4'b1111; din = 12'hfff;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_sel", 32'(sel), 32'h0);
            check("rst_dout", 32'(dout), 32'h0);
            check("rst_dvalid", 32'(dvalid), 32'h0);
        end
        rst = 1'b0;

        // single requester 2
        req = 4'b0100; din = 12'b000_101_000_000;
        tick();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_sel", 32'(sel), 32'd2);
        tick();
        check("single_dout", 32'(dout), 32'b101);
        check("single_dvalid", 32'(dvalid), 32'd1);

        // round robin: each owner drops its request for one cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = rr_req[i];
            din = 12'($urandom);
            tick();
            check("rr_sel", 32'(sel), 32'(rr_exp[i]));
        end

        // back-to-back handover 1 -> 3, then pointer wrapped to 0
        do_reset();
        req = 4'b0010; tick();
        check("b2b_first", 32'(gnt), 32'h2);
        req = 4'b1000; tick();
        check("b2b_next", 32'(gnt), 32'h8);
        req = 4'b0011; tick();
        check("b2b_ptr0", 32'(sel), 32'd0);

        // two requesters held continuously
        do_reset();
        req = 4'b0011;
        for (int j = 0; j < 12; j++) begin
            tick();
`ifdef MUX_ARB_BURST_LIMIT_EN
            check("burst_gnt", 32'(gnt), ((j / 4) % 2) ? 32'h2 : 32'h1);
`else
            check("hold_gnt", 32'(gnt), 32'h1);
`endif
        end

        // reset mid-grant, then search restarts at pointer 0
        do_reset();
        req = 4'b0100; tick();
        check("mid_gnt", 32'(gnt), 32'h4);
        rst = 1'b1; tick();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        rst = 1'b0; req = 4'b1100; tick();
        check("mid_after", 32'(gnt), 32'h4);

        // random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            din = 12'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
